// File: rtl/button_event_scheduler.sv
// Turns button presses and auto-repeat ticks into a single valid/ready event stream.
// Four buttons share one output register through a round-robin arbiter.
module button_event_scheduler #(
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_level,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_id,
    output logic       evt_repeat,
    output logic       drop_pulse
);

    // state   | meaning
    // IDLE    | no sole button is being tracked for auto-repeat
    // DELAY   | sole button held, waiting for the first repeat tick
    // REPEAT  | sole button still held, ticking every REPEAT_PERIOD cycles
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Both parameters must be at least 2.
    localparam logic [25:0] DLY_LAST = 26'(REPEAT_DELAY - 1);
    localparam logic [25:0] PER_LAST = 26'(REPEAT_PERIOD - 1);

    state_t      state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic [1:0]  held_id_q, held_id_d;
    logic [3:0]  btn_prev_q;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  rep_q, rep_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic        evt_valid_q, evt_valid_d;
    logic [1:0]  evt_id_q, evt_id_d;
    logic        evt_repeat_q, evt_repeat_d;
    logic        drop_q, drop_d;

    logic [3:0]  press;
    logic [3:0]  held_oh;
    logic        lvl_onehot;
    logic [1:0]  lvl_idx;
    logic        tick;
    logic [3:0]  tick_oh;
    logic [3:0]  ev;
    logic [3:0]  ev_rep;
    logic [3:0]  drop_vec;
    logic [3:0]  accept;
    logic        free;
    logic        gnt_vld;
    logic [1:0]  gnt_id;
    logic [1:0]  srch_idx;
    logic [3:0]  gnt_oh;

    assign press      = btn_level & ~btn_prev_q;
    assign held_oh    = 4'b0001 << held_id_q;
    assign lvl_onehot = (btn_level != 4'd0) && ((btn_level & (btn_level - 4'd1)) == 4'd0);

    always_comb begin
        lvl_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (btn_level[i]) lvl_idx = 2'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        held_id_d = held_id_q;
        tick      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lvl_onehot && press[lvl_idx]) begin
                    state_d   = ST_DELAY;
                    held_id_d = lvl_idx;
                    cnt_d     = 26'd0;
                end
            end
            ST_DELAY: begin
                if (btn_level != held_oh) begin
                    state_d = ST_IDLE;
                    cnt_d   = 26'd0;
                end else if (cnt_q == DLY_LAST) begin
                    tick    = 1'b1;
                    cnt_d   = 26'd0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            ST_REPEAT: begin
                if (btn_level != held_oh) begin
                    state_d = ST_IDLE;
                    cnt_d   = 26'd0;
                end else if (cnt_q == PER_LAST) begin
                    tick  = 1'b1;
                    cnt_d = 26'd0;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 26'd0;
            end
        endcase
    end

    assign tick_oh = tick ? held_oh : 4'd0;
    assign ev      = press | tick_oh;
    // A fresh press outranks a coincident tick on the same button.
    assign ev_rep  = tick_oh & ~press;

    assign free = ~evt_valid_q | evt_ready;

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = 2'd0;
        srch_idx = 2'd0;
        if (free) begin
            for (int k = 1; k <= 4; k++) begin
                srch_idx = last_grant_q + 2'(k);
                if (!gnt_vld && pending_q[srch_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = srch_idx;
                end
            end
        end
    end

    assign gnt_oh = gnt_vld ? (4'b0001 << gnt_id) : 4'd0;

    // An event landing on a still-pending, ungranted button is discarded.
    assign drop_vec  = ev & pending_q & ~gnt_oh;
    assign accept    = ev & ~drop_vec;
    assign pending_d = (pending_q & ~gnt_oh) | accept;
    assign rep_d     = (rep_q & ~accept) | (ev_rep & accept);
    assign drop_d    = |drop_vec;

    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_id_d     = evt_id_q;
        evt_repeat_d = evt_repeat_q;
        last_grant_d = last_grant_q;
        if (gnt_vld) begin
            evt_valid_d  = 1'b1;
            evt_id_d     = gnt_id;
            evt_repeat_d = rep_q[gnt_id];
            last_grant_d = gnt_id;
        end else if (free) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 26'd0;
            held_id_q    <= 2'd0;
            btn_prev_q   <= 4'd0;
            pending_q    <= 4'd0;
            rep_q        <= 4'd0;
            last_grant_q <= 2'd3;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= 2'd0;
            evt_repeat_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            held_id_q    <= held_id_d;
            btn_prev_q   <= btn_level;
            pending_q    <= pending_d;
            rep_q        <= rep_d;
            last_grant_q <= last_grant_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            evt_repeat_q <= evt_repeat_d;
            drop_q       <= drop_d;
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_id     = evt_id_q;
    assign evt_repeat = evt_repeat_q;
    assign drop_pulse = drop_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with an event-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_button_event_scheduler;

    localparam int RD = 8;
    localparam int RP = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_repeat;
    logic       drop_pulse;

    button_event_scheduler #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_level  (btn_level),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_id     (evt_id),
        .evt_repeat (evt_repeat),
        .drop_pulse (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending flags per button, a rotating grant pointer,
    // and auto-repeat derived from how long a sole button has been held.
    bit [3:0] m_pend, m_rep, m_prev;
    int       m_last;
    bit       m_valid, m_repo, m_drop;
    int       m_id;
    bit       run_act;
    int       run_id, run_start, edge_n;

    // Accepted-event tallies taken from the DUT handshake.
    int acc_press[4];
    int acc_rep[4];
    int drops;
    int acc_seq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0; m_rep = '0; m_prev = '0; m_last = 3;
            m_valid = 0; m_repo = 0; m_drop = 0; m_id = 0;
            run_act = 0; run_id = 0; run_start = 0; edge_n = 0;
        end else begin
            bit [3:0] b, press, np, nr;
            bit       tick, free, drop;
            int       g, age, c;
            bit [3:0] run_oh;

            if (evt_valid && evt_ready) begin
                if (evt_repeat) acc_rep[evt_id]++;
                else acc_press[evt_id]++;
                acc_seq.push_back(int'(evt_id));
            end
            if (drop_pulse) drops++;

            edge_n++;
            b      = btn_level;
            press  = b & ~m_prev;
            run_oh = 4'b0001 << run_id;
            tick   = 0;
            if (run_act && b == run_oh) begin
                age = edge_n - run_start;
                if (age == RD || (age > RD && (age - RD) % RP == 0)) tick = 1;
            end
            free = !m_valid || evt_ready;
            g = -1;
            if (free) begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last + k) % 4;
                    if (g < 0 && m_pend[c]) g = c;
                end
            end
            drop = 0;
            np = m_pend; nr = m_rep;
            for (int i = 0; i < 4; i++) begin
                bit e;
                e = press[i] || (tick && i == run_id);
                if (i == g) np[i] = 0;
                if (e) begin
                    if (m_pend[i] && i != g) drop = 1;
                    else begin
                        np[i] = 1;
                        nr[i] = !press[i];
                    end
                end
            end
            if (g >= 0) begin
                m_valid = 1; m_id = g; m_repo = m_rep[g]; m_last = g;
            end else if (free) begin
                m_valid = 0;
            end
            m_drop = drop;
            m_pend = np; m_rep = nr;
            if (run_act && b != run_oh) run_act = 0;
            else if (!run_act && $countones(b) == 1) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i] && press[i]) begin
                        run_act = 1; run_id = i; run_start = edge_n;
                    end
                end
            end
            m_prev = b;
        end
    end

    always @(negedge clk) begin
        chk("model_valid", int'(evt_valid), int'(m_valid));
        chk("model_drop", int'(drop_pulse), int'(m_drop));
        if (m_valid) begin
            chk("model_id", int'(evt_id), m_id);
            chk("model_repeat", int'(evt_repeat), int'(m_repo));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            acc_press[i] = 0;
            acc_rep[i]   = 0;
        end
        drops = 0;
        acc_seq.delete();
    endtask

    initial begin
        rst_n = 1'b0; btn_level = 4'd0; evt_ready = 1'b1;
        clear_counts();
        step(2);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_id", int'(evt_id), 0);
        chk("rst_repeat", int'(evt_repeat), 0);
        chk("rst_drop", int'(drop_pulse), 0);
        rst_n = 1'b1;
        step(2);

        // All four pressed together, twice: round-robin from index 0 each time.
        clear_counts();
        btn_level = 4'hF; step(6);
        btn_level = 4'h0; step(2);
        btn_level = 4'hF; step(6);
        btn_level = 4'h0; step(2);
        chk("rr_count", acc_seq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < acc_seq.size()) chk("rr_order", acc_seq[i], i % 4);
        end

        // Single press on button 2: one-cycle event one edge after the press.
        clear_counts();
        btn_level = 4'b0100; step(1);
        chk("p2_valid_k", int'(evt_valid), 0);
        step(1);
        chk("p2_valid_k1", int'(evt_valid), 1);
        chk("p2_id_k1", int'(evt_id), 2);
        chk("p2_repeat_k1", int'(evt_repeat), 0);
        step(1);
        chk("p2_valid_k2", int'(evt_valid), 0);
        btn_level = 4'd0; step(3);

        // Back-pressure on button 1: one queued event, one dropped.
        clear_counts();
        evt_ready = 1'b0;
        btn_level = 4'b0010; step(2);
        chk("bp_valid", int'(evt_valid), 1);
        chk("bp_id", int'(evt_id), 1);
        btn_level = 4'b0000; step(1);
        btn_level = 4'b0010; step(1);
        btn_level = 4'b0000; step(1);
        btn_level = 4'b0010; step(1);
        chk("bp_drop_hi", int'(drop_pulse), 1);
        btn_level = 4'b0000; step(1);
        chk("bp_drop_lo", int'(drop_pulse), 0);
        chk("bp_id_hold", int'(evt_id), 1);
        evt_ready = 1'b1; step(4);
        chk("bp_id1_events", acc_press[1], 2);
        chk("bp_drops", drops, 1);

        // Button 3 held alone through 27 sampled edges: ticks at +8,+12,+16,+20,+24.
        clear_counts();
        btn_level = 4'b1000;
        for (int j = 1; j <= 27; j++) begin
            step(1);
            if (j == 9) chk("hold_valid_pre", int'(evt_valid), 0);
            if (j == 10) begin
                chk("hold_first_rep_valid", int'(evt_valid), 1);
                chk("hold_first_rep_flag", int'(evt_repeat), 1);
                chk("hold_first_rep_id", int'(evt_id), 3);
            end
        end
        btn_level = 4'd0; step(4);
        chk("hold_press", acc_press[3], 1);
        chk("hold_repeats", acc_rep[3], 5);

        // Second button joins during the delay: tracking stops, no repeats.
        clear_counts();
        btn_level = 4'b0001; step(3);
        btn_level = 4'b0101; step(15);
        btn_level = 4'b0000; step(3);
        chk("two_press0", acc_press[0], 1);
        chk("two_press2", acc_press[2], 1);
        chk("two_repeats", acc_rep[0] + acc_rep[1] + acc_rep[2] + acc_rep[3], 0);

        // Reset mid-repeat with an event on the output.
        clear_counts();
        evt_ready = 1'b0;
        btn_level = 4'b1000; step(14);
        chk("mr_valid_before", int'(evt_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", int'(evt_valid), 0);
        chk("mr_id", int'(evt_id), 0);
        chk("mr_repeat", int'(evt_repeat), 0);
        chk("mr_drop", int'(drop_pulse), 0);
        step(2);
        chk("mr_valid_held", int'(evt_valid), 0);
        rst_n = 1'b1; evt_ready = 1'b1;
        step(1);
        chk("mr_post_k", int'(evt_valid), 0);
        step(1);
        chk("mr_post_valid", int'(evt_valid), 1);
        chk("mr_post_id", int'(evt_id), 3);
        chk("mr_post_repeat", int'(evt_repeat), 0);
        btn_level = 4'd0; step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
